// File: rtl/intersection_phase_scheduler.sv
// Sensor debounce, sticky requests and round-robin/starvation phase pick for the light sequencer.
// Optional emergency preemption is built in when PHASE_PREEMPT_EN is defined.
module intersection_phase_scheduler #(
    parameter int NUM_PH   = 3,
    parameter int DEB_CYC  = 2,
    parameter int MAX_WAIT = 15,
    parameter int AGE_W    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_PH-1:0]         sensor,
    input  logic                      grant_ready,
    input  logic                      phase_busy,
    output logic                      grant_valid,
    output logic [$clog2(NUM_PH)-1:0] grant_phase,
    output logic [NUM_PH-1:0]         pending,
    output logic                      starve
`ifdef PHASE_PREEMPT_EN
    ,
    input  logic                      preempt_req,
    input  logic [$clog2(NUM_PH)-1:0] preempt_phase,
    output logic                      preempt_active
`endif
);

    localparam int PW = $clog2(NUM_PH);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam logic [DW-1:0]    DEB_MAX = DW'(DEB_CYC);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);
    localparam logic [PW-1:0]    LAST_RST = PW'(NUM_PH - 1);

    typedef enum logic [1:0] {IDLE, OFFER, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [PW-1:0]     last_q, last_d;
    logic              pre_q, pre_d;
    logic [NUM_PH-1:0] pend_q, pend_d;
    logic [DW-1:0]     deb_q [NUM_PH];
    logic [DW-1:0]     deb_d [NUM_PH];
    logic [AGE_W-1:0]  age_q [NUM_PH];
    logic [AGE_W-1:0]  age_d [NUM_PH];

    logic [NUM_PH-1:0] deb;
    logic [NUM_PH-1:0] is_cur;
    logic [NUM_PH-1:0] starved;
    logic              accept;
    logic              found;
    logic [PW-1:0]     sel;
    int                idx;

    assign accept = (state_q == OFFER) && grant_ready;

    always_comb begin
        for (int i = 0; i < NUM_PH; i++) begin
            deb[i]     = (deb_q[i] == DEB_MAX);
            is_cur[i]  = (phase_q == PW'(i));
            starved[i] = pend_q[i] && (age_q[i] == AGE_MAX);
            if (!sensor[i]) begin
                deb_d[i] = '0;
            end else if (deb_q[i] == DEB_MAX) begin
                deb_d[i] = deb_q[i];
            end else begin
                deb_d[i] = deb_q[i] + 1'b1;
            end
        end
    end

    // Starved phases win by lowest index; otherwise rotate past the last served phase.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_PH; i++) begin
            if (!found && starved[i]) begin
                sel   = PW'(i);
                found = 1'b1;
            end
        end
        for (int k = 1; k <= NUM_PH; k++) begin
            idx = (int'(last_q) + k) % NUM_PH;
            if (!found && pend_q[idx]) begin
                sel   = PW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PH; i++) begin
            pend_d[i] = pend_q[i];
            age_d[i]  = age_q[i];
            if (accept && is_cur[i]) begin
                pend_d[i] = 1'b0;
                age_d[i]  = '0;
            end else begin
                if (deb[i] && !(state_q != IDLE && is_cur[i])) begin
                    pend_d[i] = 1'b1;
                end
                if (pend_q[i] && !(state_q == OFFER && is_cur[i]) &&
                    !pre_q && age_q[i] != AGE_MAX) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        phase_d = phase_q;
        last_d  = last_q;
        pre_d   = pre_q;
        unique case (state_q)
            IDLE: begin
`ifdef PHASE_PREEMPT_EN
                if (preempt_req) begin
                    state_d = OFFER;
                    valid_d = 1'b1;
                    phase_d = preempt_phase;
                    pre_d   = 1'b1;
                end else
`endif
                if (|pend_q) begin
                    state_d = OFFER;
                    valid_d = 1'b1;
                    phase_d = sel;
                end
            end
            OFFER: begin
                if (grant_ready) begin
                    state_d = WAIT_BUSY;
                    valid_d = 1'b0;
                    last_d  = phase_q;
                end
            end
            WAIT_BUSY: begin
                if (phase_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!phase_busy) begin
                    state_d = IDLE;
                    pre_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            phase_q <= '0;
            last_q  <= LAST_RST;
            pre_q   <= 1'b0;
            pend_q  <= '0;
            for (int i = 0; i < NUM_PH; i++) begin
                deb_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            phase_q <= phase_d;
            last_q  <= last_d;
            pre_q   <= pre_d;
            pend_q  <= pend_d;
            for (int i = 0; i < NUM_PH; i++) begin
                deb_q[i] <= deb_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

    assign grant_valid = valid_q;
    assign grant_phase = phase_q;
    assign pending     = pend_q;
    assign starve      = |starved;
`ifdef PHASE_PREEMPT_EN
    assign preempt_active = pre_q;
`else
    logic unused_pre;
    assign unused_pre = pre_q;
`endif

endmodule
